fifo_rr_arbiter: RTL
====================

Name: fifo_rr_arbiter

Overview:
- Downstream consumer of the per-class FIFO bank.
- Watches N_IN FIFO empty flags and issues round-robin pops.
- Captures each popped word and pushes it into a single output FIFO, gated by that FIFO's alm_full back-pressure.
- Arbitrates only while the shared 4-bit system state equals the ACTIVE encoding.

Parameters:
- DATA_W, 10, word width; matches FIFO data_in/data_out.
- N_IN, 4, number of input FIFOs; must be a power of 2, at least 2.
- ACTIVE_ST, 4'b1000, state encoding in which arbitration is enabled.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- state, input, 4, system state from the main control FSM.
- empty_in, input, N_IN, empty flag of each input FIFO; bit i belongs to FIFO i.
- data_in, input, N_IN*DATA_W, concatenated FIFO data_out buses; FIFO i occupies [i*DATA_W +: DATA_W].
- alm_full_out, input, 1, almost-full flag of the downstream FIFO.
- pop_out, output, N_IN, one-hot pop strobes to the input FIFOs.
- push_out, output, 1, push strobe to the downstream FIFO.
- data_out, output, DATA_W, word to the downstream FIFO.
- grant_idx, output, log2(N_IN), index of the FIFO whose word is on data_out.

Behaviour:
- Reset (async, active-high): pop_out=0, push_out=0, data_out=0, grant_idx=0, last_grant=N_IN-1, so the first grant goes to FIFO 0. All pipeline valid bits are cleared.
- Every output is registered; there are no combinational input-to-output paths.
- Input FIFO read timing: an input FIFO samples pop on a clock edge and presents the popped word on its data_out right after that same edge.
- Eligibility of FIFO i at edge E requires all four of:
  - state==ACTIVE_ST;
  - empty_in[i]==0;
  - alm_full_out==0;
  - FIFO i was not popped on the edge E drives (pop_out[i] currently 0). This masks the stale empty flag, because empty_in lags the pop by one cycle.
- Round-robin grant:
  - Search indices last_grant+1, last_grant+2, ... mod N_IN; the first eligible index wins.
  - On a win: pop_out <= onehot(win), last_grant <= win. Otherwise pop_out <= 0.
  - At most one pop per cycle; back-to-back pops to different FIFOs are allowed every cycle.
- Pipeline (pop_out[g] goes high after edge k):
  - Edge k+1: FIFO g pops; stage-1 valid and index g are registered.
  - Edge k+2: data_out <= data_in slice g, grant_idx <= g, push_out <= 1 for one cycle.
  - Pop-to-push latency is 2 cycles; throughput is 1 word per cycle.
- Single non-empty FIFO: that FIFO is popped every other cycle because of the mask.
- Back-pressure:
  - alm_full_out only blocks new pops.
  - Up to 2 words already in flight are still pushed.
  - The downstream FIFO's sup_Threshold must leave at least 2 free entries.
- State leaves ACTIVE_ST mid-operation: no new pops; in-flight words complete their pushes; last_grant is held.
- Reset mid-operation: in-flight words are discarded; pop_out and push_out drop immediately.
- push_out=0 holds data_out and grant_idx at their last values.

Optional Feature:
- Macro: ARB_STRICT_PRIO0_EN.
- When defined: FIFO 0 wins whenever it is eligible. Indices 1..N_IN-1 round-robin among themselves. last_grant tracks only non-zero grants and resets to N_IN-1.
- When undefined: pure round-robin over all N_IN FIFOs, as above.

Test Plan:
- Reset, then state=ACTIVE_ST, all empty_in=4'b0000, alm_full_out=0 -> pop_out sequence 0001,0010,0100,1000,0001. push_out is high from the 3rd cycle, with grant_idx 0,1,2,3.
- Only FIFO 2 non-empty, data 10'h2A5 -> pop_out=0100 every other cycle. data_out=10'h2A5 and grant_idx=2 exactly 2 cycles after each pop.
- Continuous traffic, alm_full_out rises for 3 cycles -> pop_out=0 during those 3 cycles. Exactly 2 trailing pushes follow. The grant order resumes from last_grant+1.
- state switches from ACTIVE_ST to 4'b0100 with 2 words in flight -> no new pops; 2 pushes complete; push_out=0 afterwards.
- Assert reset between pop and push -> pop_out, push_out, data_out and grant_idx all 0 within the same cycle. First grant after release is FIFO 0.
- ARB_STRICT_PRIO0_EN defined, all FIFOs non-empty -> pop order 0,1,0,2,0,3 (FIFO 0 is masked every other cycle).

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin pop arbiter moving words from N_IN input FIFOs into one output FIFO
// Optional ARB_STRICT_PRIO0_EN: FIFO 0 gets strict priority, FIFOs 1..N_IN-1 round-robin among themselves.
module fifo_rr_arbiter #(
  parameter int         DATA_W    = 10,
  parameter int         N_IN      = 4,
  parameter logic [3:0] ACTIVE_ST = 4'b1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                state,
  input  logic [N_IN-1:0]           empty_in,
  input  logic [N_IN*DATA_W-1:0]    data_in,
  input  logic                      alm_full_out,
  output logic [N_IN-1:0]           pop_out,
  output logic                      push_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [$clog2(N_IN)-1:0]   grant_idx
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  logic [N_IN-1:0]   pop_q, pop_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  grant_q, grant_d;

  logic [N_IN-1:0]   eligible;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  idx_c;

  // A FIFO popped on the coming edge still shows a stale empty flag, so it is masked.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_IN; i++) begin
      eligible[i] = (state == ACTIVE_ST) && !empty_in[i] && !alm_full_out && !pop_q[i];
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_c     = '0;
`ifdef ARB_STRICT_PRIO0_EN
    if (eligible[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
    for (int off = 1; off <= N_IN; off++) begin
      idx_c = last_grant_q + IDX_W'(off);
      if (!win_found && (idx_c != '0) && eligible[idx_c]) begin
        win_found = 1'b1;
        win_idx   = idx_c;
      end
    end
`else
    for (int off = 1; off <= N_IN; off++) begin
      idx_c = last_grant_q + IDX_W'(off);
      if (!win_found && eligible[idx_c]) begin
        win_found = 1'b1;
        win_idx   = idx_c;
      end
    end
`endif
  end

  always_comb begin
    pop_d        = '0;
    last_grant_d = last_grant_q;
    if (win_found) begin
      pop_d[win_idx] = 1'b1;
`ifdef ARB_STRICT_PRIO0_EN
      if (win_idx != '0) last_grant_d = win_idx;
`else
      last_grant_d = win_idx;
`endif
    end

    s1_valid_d = |pop_q;
    s1_idx_d   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pop_q[i]) s1_idx_d = IDX_W'(i);
    end

    // The popped word appears on data_in one edge after the pop, so stage 1 only carries the index.
    push_d  = s1_valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (s1_valid_q) begin
      data_d  = data_in[int'(s1_idx_q) * DATA_W +: DATA_W];
      grant_d = s1_idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_q        <= '0;
      last_grant_q <= LAST_IDX;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      push_q       <= 1'b0;
      data_q       <= '0;
      grant_q      <= '0;
    end else begin
      pop_q        <= pop_d;
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      push_q       <= push_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
    end
  end

  assign pop_out   = pop_q;
  assign push_out  = push_q;
  assign data_out  = data_q;
  assign grant_idx = grant_q;

endmodule
